uart_rcv: RTL and testbench

UART_RCV -- requirements
Module: uart_rcv

---
 rtl/uart_rcv.sv | 122 ++++++++++++
 tb/tb_uart_rcv.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/uart_rcv.sv
// 8N1 UART receiver: two-flop input synchronizer, mid-bit sampling FSM and a
// single-entry output buffer with frame-error and overrun pulses.
module uart_rcv #(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_data,
    output logic [7:0] data_out,
    output logic       data_valid,
    input  logic       data_ack,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] HALF_LAST = BW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    state_e          state_q, state_d;
    logic            sync1_q, rx_sync_q;
    logic [BW-1:0]   baud_q, baud_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      data_q, data_d;
    logic            valid_q, valid_d;
    logic            ferr_q, ferr_d;
    logic            ovr_q, ovr_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            sync1_q   <= 1'b1;
            rx_sync_q <= 1'b1;
            baud_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync1_q   <= rx_data;
            rx_sync_q <= sync1_q;
            baud_q    <= baud_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = valid_q;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;

        // A load in STOP below overrides this clear when both coincide.
        if (data_ack && valid_q) valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (!rx_sync_q) begin
                    state_d = START;
                    baud_d  = '0;
                end
            end
            START: begin
                if (baud_q == HALF_LAST) begin
                    baud_d = '0;
                    bit_d  = '0;
                    state_d = rx_sync_q ? IDLE : DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (baud_q == BIT_LAST) begin
                    baud_d  = '0;
                    shift_d = {rx_sync_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = STOP;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            STOP: begin
                if (baud_q == BIT_LAST) begin
                    state_d = IDLE;
                    baud_d  = '0;
                    if (!rx_sync_q) begin
                        ferr_d = 1'b1;
                    end else if (valid_q && !data_ack) begin
                        ovr_d = 1'b1;
                    end else begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign data_out   = data_q;
    assign data_valid = valid_q;
    assign frame_err  = ferr_q;
    assign overrun    = ovr_q;
    assign busy       = (state_q != IDLE);
endmodule

// File: tb/tb_uart_rcv.sv
// Directed bench for uart_rcv: frames driven bit by bit, received bytes
// checked against a queue of expected bytes filled as frames are sent.
module tb_uart_rcv;
    localparam int CPB = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx_data = 1'b1;
    logic       data_ack = 1'b0;
    logic [7:0] data_out;
    logic       data_valid, frame_err, overrun, busy;

    int checks = 0;
    int errors = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int fe_base, ov_base;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    uart_rcv #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data),
        .data_out(data_out), .data_valid(data_valid), .data_ack(data_ack),
        .frame_err(frame_err), .overrun(overrun), .busy(busy)
    );

    // Counts high cycles, so a single-cycle pulse adds exactly one.
    always @(negedge clk) begin
        if (frame_err === 1'b1) fe_cnt++;
        if (overrun === 1'b1) ov_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives the first ncyc cycles of a frame; starts and ends on a negedge.
    task automatic drive_frame(input logic [7:0] b, input logic stop, input int ncyc);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        for (int c = 0; c < ncyc; c++) begin
            rx_data = f[c / CPB];
            @(negedge clk);
        end
    endtask

    task automatic send(input logic [7:0] b);
        exp_q.push_back(b);
        drive_frame(b, 1'b1, 10 * CPB);
    endtask

    task automatic consume(input string tag);
        logic [7:0] e;
        chk({tag, "_valid"}, {31'd0, data_valid}, 32'd1);
        if (exp_q.size() == 0) begin
            chk({tag, "_queue_empty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_data"}, {24'd0, data_out}, {24'd0, e});
        end
        data_ack = 1'b1;
        @(negedge clk);
        data_ack = 1'b0;
        chk({tag, "_cleared"}, {31'd0, data_valid}, 32'd0);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_data", {24'd0, data_out}, 32'h00);
        chk("rst_valid", {31'd0, data_valid}, 32'd0);
        chk("rst_ferr", {31'd0, frame_err}, 32'd0);
        chk("rst_ovr", {31'd0, overrun}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b1;
        repeat (4) @(negedge clk);

        // 0xA5 with exact timing: T0 is the third edge after the line drops
        fe_base = fe_cnt; ov_base = ov_cnt;
        exp_q.push_back(8'hA5);
        drive_frame(8'hA5, 1'b1, 78);
        chk("a5_valid_t76", {31'd0, data_valid}, 32'd0);
        chk("a5_busy_stop", {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk("a5_valid_t77", {31'd0, data_valid}, 32'd1);
        chk("a5_busy_after", {31'd0, busy}, 32'd0);
        @(negedge clk);
        consume("a5");
        chk("a5_no_pulses", fe_cnt + ov_cnt, fe_base + ov_base);
        repeat (4) @(negedge clk);

        // Back-to-back 0x3C, 0xC3 with an ack during the second frame
        fe_base = fe_cnt; ov_base = ov_cnt;
        send(8'h3C);
        fork
            send(8'hC3);
            consume("b2b_3c");
        join
        consume("b2b_c3");
        chk("b2b_no_ovr", ov_cnt, ov_base);
        chk("b2b_no_ferr", fe_cnt, fe_base);
        repeat (4) @(negedge clk);

        // Two-cycle glitch: false start, back to IDLE at T0+4
        fe_base = fe_cnt; ov_base = ov_cnt;
        rx_data = 1'b0;
        repeat (2) @(negedge clk);
        rx_data = 1'b1;
        repeat (4) @(negedge clk);
        chk("glitch_busy_t3", {31'd0, busy}, 32'd1);
        @(negedge clk);
        chk("glitch_idle_t4", {31'd0, busy}, 32'd0);
        repeat (8) @(negedge clk);
        chk("glitch_valid", {31'd0, data_valid}, 32'd0);
        chk("glitch_no_pulses", fe_cnt + ov_cnt, fe_base + ov_base);

        // 0x55 with a low stop bit
        fe_base = fe_cnt;
        drive_frame(8'h55, 1'b0, 78);
        chk("fe_before", {31'd0, frame_err}, 32'd0);
        @(negedge clk);
        chk("fe_pulse", {31'd0, frame_err}, 32'd1);
        chk("fe_valid", {31'd0, data_valid}, 32'd0);
        @(negedge clk);
        chk("fe_single", {31'd0, frame_err}, 32'd0);
        rx_data = 1'b1;
        repeat (20) @(negedge clk);
        chk("fe_count", fe_cnt, fe_base + 1);
        chk("fe_busy", {31'd0, busy}, 32'd0);

        // Overrun: 0x11 unacked, 0x22 dropped, then 0x22 with ack at stop
        ov_base = ov_cnt;
        send(8'h11);
        drive_frame(8'h22, 1'b1, 10 * CPB);
        repeat (2) @(negedge clk);
        chk("ovr_count", ov_cnt, ov_base + 1);
        chk("ovr_data_kept", {24'd0, data_out}, {24'd0, exp_q[0]});
        chk("ovr_valid_kept", {31'd0, data_valid}, 32'd1);
        exp_q.push_back(8'h22);
        drive_frame(8'h22, 1'b1, 78);
        data_ack = 1'b1;
        @(negedge clk);
        data_ack = 1'b0;
        void'(exp_q.pop_front());
        chk("ackload_valid", {31'd0, data_valid}, 32'd1);
        chk("ackload_data", {24'd0, data_out}, {24'd0, exp_q[0]});
        repeat (2) @(negedge clk);
        chk("ackload_no_ovr", ov_cnt, ov_base + 1);
        consume("ackload");
        repeat (4) @(negedge clk);

        // Reset at T0+40 of a frame, then a clean 0x7E
        fe_base = fe_cnt; ov_base = ov_cnt;
        drive_frame(8'h7E, 1'b1, 43);
        reset = 1'b0;
        rx_data = 1'b1;
        #1;
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_valid", {31'd0, data_valid}, 32'd0);
        chk("abort_data", {24'd0, data_out}, 32'h00);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        repeat (40) @(negedge clk);
        chk("abort_stays_idle", {31'd0, busy}, 32'd0);
        chk("abort_no_pulses", fe_cnt + ov_cnt, fe_base + ov_base);
        send(8'h7E);
        consume("after_abort");
        repeat (4) @(negedge clk);
        chk("sb_drained", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
